// File: rtl/fpu_share_if.sv
// Hart/FPU side bundle for the shared FPU arbiter.
// slave: arbiter view; master: harts plus FPU view.
interface fpu_share_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*7-1:0]  req_funct7;
  logic [NREQ*3-1:0]  req_funct3;
  logic [NREQ-1:0]    req_rs2b0;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_data;
  logic               fpu_valid;
  logic [31:0]        fpu_a;
  logic [31:0]        fpu_b;
  logic [6:0]         fpu_funct7;
  logic [2:0]         fpu_funct3;
  logic               fpu_rs2b0;
  logic [31:0]        fpu_r;

  modport slave (
    input  req_valid, req_a, req_b,
    input  req_funct7, req_funct3, req_rs2b0,
    input  fpu_r,
    output req_ready, resp_valid, resp_data,
    output fpu_valid, fpu_a, fpu_b,
    output fpu_funct7, fpu_funct3, fpu_rs2b0
  );

  modport master (
    output req_valid, req_a, req_b,
    output req_funct7, req_funct3, req_rs2b0,
    output fpu_r,
    input  req_ready, resp_valid, resp_data,
    input  fpu_valid, fpu_a, fpu_b,
    input  fpu_funct7, fpu_funct3, fpu_rs2b0
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// Round-robin share of one fixed-latency FPU among NREQ harts.
// Optional FPU_SHARE_PERF_EN adds per-hart issue/stall counters.
module fpu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int FPU_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  fpu_share_if.slave bus
`ifdef FPU_SHARE_PERF_EN
  ,
  output logic [NREQ*32-1:0] perf_issue,
  output logic [NREQ*32-1:0] perf_stall
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] busy_q, busy_d;
  logic [NREQ-1:0] elig, gnt, done;
  logic [IW-1:0]   rr_q, rr_d, win;
  logic            found;
  logic [FPU_LAT-1:0] tv_q;
  logic [IW-1:0]   ti_q [FPU_LAT];
  logic [NREQ-1:0] resp_valid_q;
  logic [31:0]     resp_data_q;

  // Round-robin pick of the first eligible hart from rr_q
  always_comb begin
    int j;
    elig  = bus.req_valid & ~busy_q;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int o = 0; o < NREQ; o++) begin
      j = (int'(rr_q) + o) % NREQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
    gnt = found ? (NREQ'(1) << win) : '0;
  end

  // Operand mux toward the FPU; zero when idle
  always_comb begin
    bus.fpu_valid  = found;
    bus.fpu_a      = '0;
    bus.fpu_b      = '0;
    bus.fpu_funct7 = '0;
    bus.fpu_funct3 = '0;
    bus.fpu_rs2b0  = 1'b0;
    if (found) begin
      bus.fpu_a      = bus.req_a[32*int'(win) +: 32];
      bus.fpu_b      = bus.req_b[32*int'(win) +: 32];
      bus.fpu_funct7 = bus.req_funct7[7*int'(win) +: 7];
      bus.fpu_funct3 = bus.req_funct3[3*int'(win) +: 3];
      bus.fpu_rs2b0  = bus.req_rs2b0[win];
    end
  end

  // Next busy set, completion decode and pointer advance
  always_comb begin
    done = '0;
    if (tv_q[FPU_LAT-1])
      done = NREQ'(1) << ti_q[FPU_LAT-1];
    busy_d = (busy_q & ~done) | gnt;
    rr_d   = rr_q;
    if (found)
      rr_d = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
  end

  // Tag pipe, busy flags, pointer and registered response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      rr_q         <= '0;
      tv_q         <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      for (int s = 0; s < FPU_LAT; s++)
        ti_q[s] <= '0;
    end else begin
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      tv_q[0] <= found;
      ti_q[0] <= win;
      for (int s = 1; s < FPU_LAT; s++) begin
        tv_q[s] <= tv_q[s-1];
        ti_q[s] <= ti_q[s-1];
      end
      resp_valid_q <= done;
      resp_data_q  <= tv_q[FPU_LAT-1] ? bus.fpu_r : '0;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

`ifdef FPU_SHARE_PERF_EN
  logic [31:0] pi_q [NREQ];
  logic [31:0] ps_q [NREQ];

  // Per-hart issue and stall counters, wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        pi_q[i] <= '0;
        ps_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && gnt[i])
          pi_q[i] <= pi_q[i] + 32'd1;
        if (bus.req_valid[i] && !gnt[i])
          ps_q[i] <= ps_q[i] + 32'd1;
      end
    end
  end

  // Flatten counters onto the perf ports
  always_comb begin
    perf_issue = '0;
    perf_stall = '0;
    for (int i = 0; i < NREQ; i++) begin
      perf_issue[32*i +: 32] = pi_q[i];
      perf_stall[32*i +: 32] = ps_q[i];
    end
  end
`endif
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter (NREQ=4, FPU_LAT=2).
// FPU model: two-stage pipe computing a+b+funct3.
module tb_fpu_share_arbiter;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  fpu_share_if #(.NREQ(4)) bus ();

`ifdef FPU_SHARE_PERF_EN
  logic [127:0] perf_issue;
  logic [127:0] perf_stall;
`endif

  fpu_share_arbiter #(
    .NREQ(4),
    .FPU_LAT(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
`ifdef FPU_SHARE_PERF_EN
    ,
    .perf_issue(perf_issue),
    .perf_stall(perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] s1, s2;
  always @(posedge clock) begin
    s1 <= bus.fpu_a + bus.fpu_b + 32'(bus.fpu_funct3);
    s2 <= s1;
  end
  assign bus.fpu_r = s2;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[32*i +: 32]    = 32'h100 * (i+1);
      bus.req_b[32*i +: 32]    = 32'h10 * (i+1);
      bus.req_funct7[7*i +: 7] = 7'd0;
      bus.req_funct3[3*i +: 3] = 3'(i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req_valid = '0;
    bus.req_rs2b0 = '0;
    set_ops();
    tick();
    tick();
    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_resp", 64'(bus.resp_valid), 64'h0);
    chk("rst_fpuv", 64'(bus.fpu_valid), 64'h0);
    chk("rst_data", 64'(bus.resp_data), 64'h0);
    tick();
    reset = 1'b0;

    // single op on hart1
    bus.req_a[63:32]   = 32'h3F800000;
    bus.req_b[63:32]   = 32'h40000000;
    bus.req_funct3[5:3] = 3'd0;
    bus.req_valid = 4'b0010;
    #2;
    chk("s_ready", 64'(bus.req_ready), 64'h2);
    chk("s_fpuv", 64'(bus.fpu_valid), 64'h1);
    chk("s_fpua", 64'(bus.fpu_a), 64'h3F800000);
    chk("s_fpub", 64'(bus.fpu_b), 64'h40000000);
    tick();
    bus.req_valid = '0;
    #2;
    chk("s_fpuv_off", 64'(bus.fpu_valid), 64'h0);
    chk("s_fpua_idle", 64'(bus.fpu_a), 64'h0);
    chk("s_resp_n1", 64'(bus.resp_valid), 64'h0);
    tick();
    #2;
    chk("s_resp_n2", 64'(bus.resp_valid), 64'h0);
    tick();
    #2;
    chk("s_resp_n3", 64'(bus.resp_valid), 64'h2);
    chk("s_data", 64'(bus.resp_data), 64'h7F800000);
    tick();
    #2;
    chk("s_resp_n4", 64'(bus.resp_valid), 64'h0);

    // busy skip and back-to-back re-issue, rr starts at 2
    set_ops();
    bus.req_valid = 4'b0100;
    #2;
    chk("b_a_ready", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = 4'b0110;
    #2;
    chk("b_b_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 4'b1100;
    #2;
    chk("b_skip_ready", 64'(bus.req_ready), 64'h8);
    chk("b_c_resp", 64'(bus.resp_valid), 64'h0);
    tick();
    bus.req_valid = 4'b0100;
    #2;
    chk("b_d_resp", 64'(bus.resp_valid), 64'h4);
    chk("b_d_data", 64'(bus.resp_data), 64'h332);
    chk("b_reissue", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    #2;
    chk("b_e_resp", 64'(bus.resp_valid), 64'h2);
    chk("b_e_data", 64'(bus.resp_data), 64'h221);
    tick();
    #2;
    chk("b_f_resp", 64'(bus.resp_valid), 64'h8);
    chk("b_f_data", 64'(bus.resp_data), 64'h443);
    tick();
    #2;
    chk("b_g_resp", 64'(bus.resp_valid), 64'h4);
    chk("b_g_data", 64'(bus.resp_data), 64'h332);
    tick();
    #2;
    chk("b_h_resp", 64'(bus.resp_valid), 64'h0);

    // all four valid from reset
    reset = 1'b1;
    #1;
    chk("c_rst_resp", 64'(bus.resp_valid), 64'h0);
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      #2;
      chk($sformatf("c_ready%0d", k),
          64'(bus.req_ready), 64'(4'b0001 << ((k-1) % 4)));
      if (k >= 4)
        chk($sformatf("c_resp%0d", k),
            64'(bus.resp_valid), 64'(4'b0001 << ((k-4) % 4)));
      tick();
    end
    bus.req_valid = '0;
    repeat (4) tick();

    // reset with two ops in flight
    bus.req_valid = 4'b0110;
    #2;
    chk("r_ready1", 64'(bus.req_ready), 64'h2);
    tick();
    #2;
    chk("r_ready2", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    reset = 1'b1;
    #2;
    chk("r_resp_in", 64'(bus.resp_valid), 64'h0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("r_resp_after%0d", k),
          64'(bus.resp_valid), 64'h0);
      tick();
    end
    bus.req_valid = 4'b0111;
    #2;
    chk("r_first", 64'(bus.req_ready), 64'h1);
    tick();
    #2;
    chk("r_second", 64'(bus.req_ready), 64'h2);
    tick();
    #2;
    chk("r_third", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    repeat (4) tick();

`ifdef FPU_SHARE_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b0101;
    tick();
    bus.req_valid = 4'b0100;
    repeat (7) tick();
    bus.req_valid = '0;
    #2;
    chk("p_stall2", 64'(perf_stall[95:64]), 64'd5);
    chk("p_issue2", 64'(perf_issue[95:64]), 64'd3);
    chk("p_issue0", 64'(perf_issue[31:0]), 64'd1);
    repeat (4) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
